// File: rtl/aer_event_packer_if.sv
// Output stream of the AER event packer: valid/ready handshake carrying
// one packed word per transfer.
interface aer_event_packer_if #(
   parameter int DATA_W = 26
);
   logic              m_valid_o;
   logic              m_ready_i;
   logic [DATA_W-1:0] m_data_o;

   // Producer side (the packer)
   modport master (
      output m_valid_o,
      output m_data_o,
      input  m_ready_i
   );

   // Consumer side
   modport slave (
      input  m_valid_o,
      input  m_data_o,
      output m_ready_i
   );
endinterface

// File: rtl/aer_event_packer.sv
// AER event packer: stamps each granted pixel address with a free-running
// timestamp, inserts timestamp-wrap and group-end marker words, and buffers
// everything in a first-word-fall-through FIFO feeding a valid/ready stream.
// Events arriving while the FIFO is full are dropped and counted; markers
// are held pending and retried until there is room.
module aer_event_packer #(
   parameter int X_W    = 4,
   parameter int Y_W    = 4,
   parameter int TS_W   = 16,
   parameter int DEPTH  = 16,
   parameter int DROP_W = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       enable_i,
   input  logic                       evt_valid_i,
   input  logic [X_W-1:0]             x_add_i,
   input  logic [Y_W-1:0]             y_add_i,
   input  logic                       grp_release_i,
   aer_event_packer_if.master         m_if,
   output logic [$clog2(DEPTH):0]     fifo_count_o,
   output logic                       overflow_o,
   output logic [DROP_W-1:0]          drop_cnt_o
);

   localparam int WORD_W = 2 + TS_W + X_W + Y_W;
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;

   localparam logic [1:0] KIND_EVT      = 2'b00;
   localparam logic [1:0] KIND_EVT_WRAP = 2'b01;
   localparam logic [1:0] KIND_WRAP     = 2'b10;
   localparam logic [1:0] KIND_GRP      = 2'b11;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == '1) ? v : v + DROP_W'(1);
   endfunction

   logic [TS_W-1:0]   ts;
   logic              wrap_pend;
   logic              grp_pend;
   logic              grp_q;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              pop;
   logic              room;
   logic              wrap_now;
   logic              grp_rise;
   logic              push;
   logic [WORD_W-1:0] wdata;
   logic              clr_wrap;
   logic              clr_grp;
   logic              drop;

   assign pop      = (count != '0) & m_if.m_ready_i;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign room     = (count != CW'(DEPTH)) | pop;
   assign wrap_now = enable_i & (ts == '1);
   assign grp_rise = enable_i & grp_release_i & ~grp_q;

   // Write selection: event beats wrap marker beats group-end marker.
   always_comb begin
      push     = 1'b0;
      wdata    = '0;
      clr_wrap = 1'b0;
      clr_grp  = 1'b0;
      drop     = 1'b0;
      if (enable_i) begin
         if (evt_valid_i) begin
            if (room) begin
               push     = 1'b1;
               wdata    = {(wrap_pend ? KIND_EVT_WRAP : KIND_EVT), ts, x_add_i, y_add_i};
               clr_wrap = wrap_pend;
            end else begin
               drop = 1'b1;
            end
         end else if (wrap_pend) begin
            if (room) begin
               push     = 1'b1;
               wdata    = {KIND_WRAP, {(WORD_W-2){1'b0}}};
               clr_wrap = 1'b1;
            end
         end else if (grp_pend) begin
            if (room) begin
               push    = 1'b1;
               wdata   = {KIND_GRP, ts, {(X_W+Y_W){1'b0}}};
               clr_grp = 1'b1;
            end
         end
      end
   end

   // Timestamp, pending markers and group-release edge register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ts        <= '0;
         wrap_pend <= 1'b0;
         grp_pend  <= 1'b0;
         grp_q     <= 1'b0;
      end else begin
         grp_q <= grp_release_i;
         if (!enable_i) begin
            ts        <= '0;
            wrap_pend <= 1'b0;
            grp_pend  <= 1'b0;
         end else begin
            ts        <= ts + TS_W'(1);
            // Writing a pending marker wins over a set arriving the same cycle.
            wrap_pend <= clr_wrap ? 1'b0 : (wrap_pend | wrap_now);
            grp_pend  <= clr_grp  ? 1'b0 : (grp_pend  | grp_rise);
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates the output.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Drop accounting for events refused by a full FIFO.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         drop_cnt_o <= '0;
         overflow_o <= 1'b0;
      end else if (drop) begin
         drop_cnt_o <= sat_inc(drop_cnt_o);
         overflow_o <= 1'b1;
      end
   end

   assign m_if.m_valid_o = (count != '0);
   assign m_if.m_data_o  = (count != '0) ? mem[rd_ptr] : '0;
   assign fifo_count_o   = count;

endmodule
